// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN training datapath: Q8.8 width, update
// control codes, the bias-gradient FSM encoding and the Q8.8 saturation helper.
package dqn_pkg;

    localparam int Q_W = 16;

    localparam logic [3:0] CTRL_IDLE      = 4'b0000;
    localparam logic [3:0] CTRL_BIAS3_UPD = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_ISSUE = 2'd2
    } b3_state_t;

    // Clamp a 32-bit signed value into the signed 16-bit range.
    function automatic logic signed [Q_W-1:0] sat16(input logic signed [31:0] v);
        logic signed [Q_W-1:0] r;
        if (v > 32'sh0000_7FFF) begin
            r = 16'sh7FFF;
        end else if (v < 32'shFFFF_8000) begin
            r = 16'sh8000;
        end else begin
            r = signed'(v[Q_W-1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/bias3_scale_sat.sv
// One lane of the bias-gradient scaler: arithmetic right shift of the
// accumulated error, negation, and saturation to a signed Q8.8 delta.
module bias3_scale_sat
    import dqn_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [Q_W-1:0]   o_delta
);

    logic signed [ACC_W-1:0] w_shifted;
    logic signed [31:0]      w_ext;
    logic signed [31:0]      w_neg;

    // Shift floors toward -inf; negation is done at 32 bits so that the
    // most-negative shifted value still negates cleanly before clamping.
    assign w_shifted = i_acc >>> SHIFT;
    assign w_ext     = 32'(w_shifted);
    assign w_neg     = -w_ext;
    assign o_delta   = sat16(w_neg);

endmodule

// File: rtl/bias3_delta_gen.sv
// Output-layer bias-gradient generator: accumulates a mini-batch of per-action
// TD errors, scales them by batch size and learning rate, and issues one delta.
module bias3_delta_gen
    import dqn_pkg::*;
#(
    parameter int BATCH_LOG2 = 2,
    parameter int LR_SHIFT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  err_valid,
    output logic                  err_ready,
    input  logic signed [Q_W-1:0] err_1,
    input  logic signed [Q_W-1:0] err_2,
    input  logic signed [Q_W-1:0] err_3,
    input  logic signed [Q_W-1:0] err_4,
    input  logic                  flush,
    output logic signed [Q_W-1:0] deltab3_1,
    output logic signed [Q_W-1:0] deltab3_2,
    output logic signed [Q_W-1:0] deltab3_3,
    output logic signed [Q_W-1:0] deltab3_4,
    output logic [3:0]            upd_ctrl,
    output logic                  busy
);

    localparam int ACC_W = Q_W + BATCH_LOG2;
    localparam int CNT_W = BATCH_LOG2 + 1;
    localparam int SHIFT = BATCH_LOG2 + LR_SHIFT;
    localparam logic [CNT_W-1:0] BATCH_N = CNT_W'(1 << BATCH_LOG2);

    b3_state_t r_state_reg;
    b3_state_t w_state_next;

    logic [CNT_W-1:0] r_cnt_reg;
    logic [CNT_W-1:0] w_cnt_inc;

    logic w_ready;
    logic w_accept;
    logic w_issue;
    logic w_clear;

    logic signed [Q_W-1:0]   w_err [4];
    logic signed [ACC_W-1:0] r_acc_reg [4];
    logic signed [Q_W-1:0]   w_d [4];
    logic signed [Q_W-1:0]   r_d_reg [4];
    logic signed [Q_W-1:0]   w_out [4];

    assign w_err[0] = err_1;
    assign w_err[1] = err_2;
    assign w_err[2] = err_3;
    assign w_err[3] = err_4;

    // Reset also masks the outputs combinationally so nothing leaks while rst is high.
    assign w_ready   = (r_state_reg == ST_IDLE) && !rst;
    assign w_accept  = err_valid && w_ready;
    assign w_issue   = (r_state_reg == ST_ISSUE) && !rst;
    assign w_clear   = rst || (r_state_reg == ST_ISSUE);
    assign w_cnt_inc = r_cnt_reg + CNT_W'(1);

    always_comb begin
        w_state_next = r_state_reg;
        case (r_state_reg)
            ST_IDLE: begin
                if (w_accept && (w_cnt_inc == BATCH_N)) begin
                    w_state_next = ST_SCALE;
                end else if (flush && (w_accept || (r_cnt_reg != '0))) begin
                    w_state_next = ST_SCALE;
                end
            end
            ST_SCALE: w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= ST_IDLE;
        end else begin
            r_state_reg <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt_reg <= '0;
        end else if (w_accept) begin
            r_cnt_reg <= w_cnt_inc;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_acc_reg[gi] <= '0;
                end else if (w_accept) begin
                    r_acc_reg[gi] <= r_acc_reg[gi] + ACC_W'(w_err[gi]);
                end
            end

            bias3_scale_sat #(
                .ACC_W (ACC_W),
                .SHIFT (SHIFT)
            ) u_scale (
                .i_acc   (r_acc_reg[gi]),
                .o_delta (w_d[gi])
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_d_reg[gi] <= '0;
                end else if (r_state_reg == ST_SCALE) begin
                    r_d_reg[gi] <= w_d[gi];
                end
            end

            assign w_out[gi] = w_issue ? r_d_reg[gi] : '0;
        end
    endgenerate

    assign err_ready = w_ready;
    assign deltab3_1 = w_out[0];
    assign deltab3_2 = w_out[1];
    assign deltab3_3 = w_out[2];
    assign deltab3_4 = w_out[3];
    assign upd_ctrl  = w_issue ? CTRL_BIAS3_UPD : CTRL_IDLE;
    assign busy      = !rst && (r_state_reg != ST_IDLE);

endmodule
